agusec_chk: RTL and testbench

- Decoder and bounds checker for the secure-pointer format written by the AGU pointer encoder.
- Takes a 64-bit encoded pointer plus an access size, and reconstructs the base and top bounds from the `ptr_exp` / `ptr_low` / `ptr_hi` / `ptr_on_low` fields.
- Checks the access against those bounds and returns a fault code.
- Sits between the AGU and the LSU request path as a 2-stage valid/ready pipeline.

---
 rtl/agusec_chk.sv | 198 +++++++++++++++++++
 tb/tb_agusec_chk.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/agusec_chk.sv
// agusec_chk - secure-pointer decoder and bounds checker.
//
// Decodes the bounds packed into the upper 20 bits of an AGU-encoded pointer,
// checks the requested access against them and returns a fault code.
// Organised as a 2-stage valid/ready pipeline with no skid buffer.
//
// Ports:
//   clk        core clock
//   rst        synchronous reset, active low
//   in_vld     request valid
//   in_rdy     request can be accepted this cycle
//   in_ptr     encoded pointer: [43:0] address, [63:44] bounds fields
//   in_sz      log2 of access size in bytes (0..3)
//   in_tag     request id
//   out_vld    result valid
//   out_rdy    consumer accepts the result
//   out_tag    id of the result
//   out_base   decoded lower bound
//   out_top    decoded upper bound (exclusive)
//   out_fault  0=ok, 1=untagged, 2=beyond top, 3=misaligned
//   fault_cnt  saturating count of accepted results with a non-zero fault

`ifndef AGUSEC_PTR_FIELDS
`define AGUSEC_PTR_FIELDS
`define PTR_ON_LOW 63
`define PTR_HI     62:56
`define PTR_LOW    55:49
`define PTR_EXP    48:44
`endif

module agusec_chk #(
  parameter int TAG_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [63:0]      in_ptr,
  input  logic [1:0]       in_sz,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [TAG_W-1:0] out_tag,
  output logic [44:0]      out_base,
  output logic [44:0]      out_top,
  output logic [1:0]       out_fault,
  output logic [CNT_W-1:0] fault_cnt
);

  typedef enum logic [1:0] {
    FLT_OK    = 2'd0,
    FLT_UNTAG = 2'd1,
    FLT_TOP   = 2'd2,
    FLT_MIS   = 2'd3
  } fault_e;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic s1_vld, s2_vld;
  logic s1_adv, s2_adv;

  always_comb begin
    s2_adv = !s2_vld || out_rdy;
    s1_adv = !s1_vld || s2_adv;
    in_rdy = s1_adv;
  end

  logic in_xfer;
  assign in_xfer = in_vld && s1_adv;

  // ---------------------------------------------------------------------------
  // Stage 1 decode (combinational, from the request)
  // ---------------------------------------------------------------------------
  logic [4:0]  dec_e;
  logic [5:0]  dec_g;
  logic [5:0]  dec_gu;
  logic [6:0]  dec_l;
  logic [6:0]  dec_h;
  logic [6:0]  dec_m;
  logic [44:0] dec_a;
  logic [44:0] dec_u;
  logic [44:0] dec_cb;
  logic [44:0] dec_ct;
  logic [44:0] dec_base;
  logic [44:0] dec_top;
  logic [44:0] dec_end;
  logic [3:0]  dec_mask;
  logic        dec_mis;
  logic        dec_untag;

  always_comb begin
    dec_e  = in_ptr[`PTR_EXP];
    dec_g  = {1'b0, dec_e} + 6'd5;
    dec_gu = dec_g + 6'd7;
    dec_l  = in_ptr[`PTR_LOW];
    dec_h  = in_ptr[`PTR_HI];
    dec_a  = {1'b0, in_ptr[43:0]};

    // Middle 7 bits at the granule position and the upper part above them.
    dec_m  = 7'(dec_a >> dec_g);
    dec_u  = dec_a >> dec_gu;

    // Borrow when the address sits below L in its window; carry when the
    // window wraps (H below L). All arithmetic is modulo 2^45.
    dec_cb = (dec_m < dec_l) ? '1 : '0;
    dec_ct = dec_cb + ((dec_h < dec_l) ? 45'd1 : 45'd0);

    dec_base = ((dec_u + dec_cb) << dec_gu) | (45'(dec_l) << dec_g);
    dec_top  = ((dec_u + dec_ct) << dec_gu) | (45'(dec_h) << dec_g);

    dec_end  = dec_a + (45'd1 << in_sz);
    dec_mask = (4'd1 << in_sz) - 4'd1;
    dec_mis  = ({1'b0, dec_a[2:0]} & dec_mask) != 4'd0;
    dec_untag = !in_ptr[`PTR_ON_LOW];
  end

  // ---------------------------------------------------------------------------
  // Stage 1 registers
  // ---------------------------------------------------------------------------
  logic [TAG_W-1:0] s1_tag;
  logic [44:0]      s1_base;
  logic [44:0]      s1_top;
  logic [44:0]      s1_end;
  logic             s1_mis;
  logic             s1_untag;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_vld   <= 1'b0;
      s1_tag   <= '0;
      s1_base  <= '0;
      s1_top   <= '0;
      s1_end   <= '0;
      s1_mis   <= 1'b0;
      s1_untag <= 1'b0;
    end else if (s1_adv) begin
      s1_vld <= in_vld;
      if (in_xfer) begin
        s1_tag   <= in_tag;
        s1_base  <= dec_base;
        s1_top   <= dec_top;
        s1_end   <= dec_end;
        s1_mis   <= dec_mis;
        s1_untag <= dec_untag;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 fault classification
  // ---------------------------------------------------------------------------
  fault_e s1_fault;

  always_comb begin
    if (s1_untag)
      s1_fault = FLT_UNTAG;
    else if (s1_mis)
      s1_fault = FLT_MIS;
    else if (s1_end > s1_top)
      s1_fault = FLT_TOP;
    else
      s1_fault = FLT_OK;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s2_vld    <= 1'b0;
      out_tag   <= '0;
      out_base  <= '0;
      out_top   <= '0;
      out_fault <= '0;
    end else if (s2_adv) begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        out_tag   <= s1_tag;
        out_base  <= s1_base;
        out_top   <= s1_top;
        out_fault <= s1_fault;
      end
    end
  end

  assign out_vld = s2_vld;

  // ---------------------------------------------------------------------------
  // Saturating fault counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      fault_cnt <= '0;
    end else if (out_vld && out_rdy && (out_fault != 2'd0) && (fault_cnt != '1)) begin
      fault_cnt <= fault_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_agusec_chk.sv
// Self-checking bench for agusec_chk: scoreboard of expected results pushed at
// request acceptance and popped when the DUT hands a result over.
module tb_agusec_chk;

  localparam int TAG_W = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_vld = 1'b0;
  logic             in_rdy;
  logic [63:0]      in_ptr = '0;
  logic [1:0]       in_sz = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_vld;
  logic             out_rdy = 1'b1;
  logic [TAG_W-1:0] out_tag;
  logic [44:0]      out_base;
  logic [44:0]      out_top;
  logic [1:0]       out_fault;
  logic [CNT_W-1:0] fault_cnt;

  agusec_chk #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_ptr(in_ptr), .in_sz(in_sz), .in_tag(in_tag),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_tag(out_tag),
    .out_base(out_base), .out_top(out_top), .out_fault(out_fault),
    .fault_cnt(fault_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [44:0]      base;
    logic [44:0]      top;
    logic [1:0]       fault;
  } exp_t;

  exp_t exp_q[$];

  int n_chk  = 0;
  int n_pass = 0;
  int acc_cnt = 0;
  int bulk_out = 0;
  logic mon_en = 1'b0;
  logic bulk   = 1'b0;
  logic [CNT_W-1:0] exp_cnt = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [63:0] mkptr(input logic on_low, input logic [6:0] h,
                                        input logic [6:0] l, input logic [4:0] e,
                                        input logic [43:0] a);
    return {on_low, h, l, e, a};
  endfunction

  // Reference decode written directly from the pointer-format definition.
  function automatic exp_t model(input logic [63:0] p, input logic [1:0] sz,
                                 input logic [TAG_W-1:0] tag);
    exp_t r;
    int unsigned g;
    logic [44:0] a, u, cb, ct, fin, lim;
    logic [6:0]  m, l, h;
    logic [44:0] tmp;
    g   = int'(p[48:44]) + 5;
    a   = {1'b0, p[43:0]};
    l   = p[55:49];
    h   = p[62:56];
    tmp = a >> g;
    m   = tmp[6:0];
    u   = a >> (g + 7);
    cb  = (m < l) ? {45{1'b1}} : 45'd0;
    ct  = cb + ((h < l) ? 45'd1 : 45'd0);
    r.tag  = tag;
    r.base = ((u + cb) << (g + 7)) | ({38'd0, l} << g);
    r.top  = ((u + ct) << (g + 7)) | ({38'd0, h} << g);
    fin = a + (45'd1 << sz);
    lim = (45'd1 << sz) - 45'd1;
    if (!p[63])                r.fault = 2'd1;
    else if ((a & lim) != 0)   r.fault = 2'd3;
    else if (fin > r.top)      r.fault = 2'd2;
    else                       r.fault = 2'd0;
    return r;
  endfunction

  // Drive one request and push its expectation when it is accepted.
  task automatic send(input logic [63:0] p, input logic [1:0] sz,
                      input logic [TAG_W-1:0] tag, input exp_t e);
    logic ok;
    ok = 1'b0;
    in_vld = 1'b1; in_ptr = p; in_sz = sz; in_tag = tag;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_rdy) begin ok = 1'b1; break; end
    end
    if (!ok) check("accept_timeout", 0, 1);
    else begin
      exp_q.push_back(e);
      acc_cnt++;
    end
    @(posedge clk); #1;
    in_vld = 1'b0;
  endtask

  task automatic send_m(input logic [63:0] p, input logic [1:0] sz, input logic [TAG_W-1:0] tag);
    send(p, sz, tag, model(p, sz, tag));
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  // Output monitor: scoreboard compare, fault counter tracking, stall stability.
  logic             prev_stall = 1'b0;
  logic [TAG_W-1:0] h_tag;
  logic [44:0]      h_base, h_top;
  logic [1:0]       h_fault;

  always @(negedge clk) begin
    if (!rst || !mon_en) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && !bulk) begin
        check("hold_tag",   out_tag,   h_tag);
        check("hold_base",  out_base,  h_base);
        check("hold_top",   out_top,   h_top);
        check("hold_fault", out_fault, h_fault);
      end
      prev_stall <= out_vld && !out_rdy;
      h_tag <= out_tag; h_base <= out_base; h_top <= out_top; h_fault <= out_fault;
      if (out_vld && out_rdy) begin
        if (bulk) begin
          bulk_out++;
        end else if (exp_q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("tag",   out_tag,   e.tag);
          check("base",  out_base,  e.base);
          check("top",   out_top,   e.top);
          check("fault", out_fault, e.fault);
          check("fault_cnt", fault_cnt, exp_cnt);
        end
        if (out_fault != 2'd0 && exp_cnt != '1) exp_cnt++;
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(input logic [TAG_W-1:0] t, input logic [44:0] b,
                              input logic [44:0] tp, input logic [1:0] f);
    exp_t r;
    r.tag = t; r.base = b; r.top = tp; r.fault = f;
    return r;
  endfunction

  initial begin
    logic [63:0] p;
    logic [4:0]  re;
    // Reset
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_in_rdy",    in_rdy,    1);
    check("rst_out_vld",   out_vld,   0);
    check("rst_fault_cnt", fault_cnt, 0);
    check("rst_out_base",  out_base,  0);
    check("rst_out_top",   out_top,   0);
    check("rst_out_fault", out_fault, 0);
    check("rst_out_tag",   out_tag,   0);
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Basic decode with latency check
    send(mkptr(1, 7'h10, 7'h01, 0, 44'h1040), 2'd3, 8'h10, mk(8'h10, 45'h1020, 45'h1200, 2'd0));
    @(negedge clk);
    check("lat_cycle1_vld", out_vld, 0);
    @(negedge clk);
    check("lat_cycle2_vld", out_vld, 1);
    drain();

    // end == top passes, end > top faults
    send(mkptr(1, 7'h10, 7'h01, 0, 44'h11FC), 2'd2, 8'h11, mk(8'h11, 45'h1020, 45'h1200, 2'd0));
    send(mkptr(1, 7'h10, 7'h01, 0, 44'h1200), 2'd2, 8'h12, mk(8'h12, 45'h1020, 45'h1200, 2'd2));
    drain();
    check("cnt_after_top", fault_cnt, 1);

    // Wrapped window (H < L)
    send(mkptr(1, 7'h02, 7'h7E, 0, 44'h2010), 2'd3, 8'h20, mk(8'h20, 45'h1FC0, 45'h2040, 2'd0));
    send(mkptr(1, 7'h02, 7'h7E, 0, 44'h2038), 2'd3, 8'h21, mk(8'h21, 45'h1FC0, 45'h2040, 2'd0));
    send(mkptr(1, 7'h02, 7'h7E, 0, 44'h2FA0), 2'd2, 8'h22, mk(8'h22, 45'h1FC0, 45'h2040, 2'd2));
    send(mkptr(1, 7'h02, 7'h7E, 0, 44'h203C), 2'd3, 8'h23, mk(8'h23, 45'h1FC0, 45'h2040, 2'd3));
    // Untagged wins over misaligned and beyond-top
    send(mkptr(0, 7'h10, 7'h01, 0, 44'h1201), 2'd2, 8'h24, mk(8'h24, 45'h1020, 45'h1200, 2'd1));
    drain();
    check("cnt_after_wrap", fault_cnt, 4);

    // Random pointers against the reference decode, including large exponents
    for (int i = 0; i < 24; i++) begin
      re = 5'($urandom_range(0, 31));
      p  = {$urandom(), $urandom()};
      p[48:44] = re;
      send_m(p, 2'($urandom_range(0, 3)), 8'(8'h40 + i));
    end
    drain();

    // Backpressure: 4 back-to-back with the consumer stalled
    out_rdy = 1'b0;
    acc_cnt = 0;
    fork
      begin
        for (int i = 0; i < 4; i++)
          send_m(mkptr(1, 7'h10, 7'h01, 0, 44'(44'h1100 + 8 * i)), 2'd3, 8'(i));
      end
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("bp_accepted", acc_cnt, 2);
        check("bp_in_rdy",   in_rdy,  0);
        check("bp_out_vld",  out_vld, 1);
        @(posedge clk); #1;
        out_rdy = 1'b1;
      end
    join
    drain();
    check("bp_accept_total", acc_cnt, 4);

    // Reset with both stages full
    out_rdy = 1'b0;
    send_m(mkptr(0, 7'h10, 7'h01, 0, 44'h1040), 2'd0, 8'hA0);
    send_m(mkptr(0, 7'h10, 7'h01, 0, 44'h1048), 2'd0, 8'hA1);
    @(negedge clk);
    check("pre_rst_full", {dut.s1_vld, dut.s2_vld}, 2'b11);
    @(posedge clk); #1;
    mon_en = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    exp_cnt = '0;
    out_rdy = 1'b1;
    @(negedge clk);
    check("mid_rst_out_vld",   out_vld,   0);
    check("mid_rst_fault_cnt", fault_cnt, 0);
    check("mid_rst_in_rdy",    in_rdy,    1);
    mon_en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_no_out", out_vld, 0);
    end
    @(posedge clk); #1;

    // Saturation: 2^CNT_W + 2 faulting results
    bulk = 1'b1;
    bulk_out = 0;
    acc_cnt = 0;
    in_vld = 1'b1;
    in_ptr = mkptr(0, 7'h10, 7'h01, 0, 44'h1040);
    in_sz  = 2'd0;
    in_tag = 8'hEE;
    for (int i = 0; i < 80000 && acc_cnt < (1 << CNT_W) + 2; i++) begin
      @(negedge clk);
      if (in_rdy) acc_cnt++;
      @(posedge clk); #1;
    end
    in_vld = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("sat_accepted", acc_cnt, (1 << CNT_W) + 2);
    check("sat_emitted",  bulk_out, (1 << CNT_W) + 2);
    check("sat_fault_cnt", fault_cnt, 16'hFFFF);
    check("sat_model_cnt", fault_cnt, exp_cnt);
    bulk = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
